mycpu_ex_ctrl: RTL and testbench
================================

# mycpu_ex_ctrl

Execute-stage controller for the myCPU pipeline. Accepts instructions from decode with a valid/allowin handshake, drives the single-cycle ALU directly, and sequences the shared multi-cycle mul/div unit through a start/done handshake. It flags arithmetic overflow as an exception, suppresses register writeback on overflow, and holds results until the memory stage accepts them.

## Interface
Parameters:
- MD_TIMEOUT, 64: maximum cycles to wait for md_done; after this, es_md_err is raised and the op completes with zero results.

Ports:
- clk  in  1  stage clock
- reset  in  1  synchronous, active-high reset
- ds_to_es_valid  in  1  decode presents an instruction
- ds_class  in  2  00 ALU, 01 ALU-trap (overflow checked), 10 MUL, 11 DIV
- ds_aluop  in  4  ALU operation code; for MUL/DIV, bit0 = signed
- ds_src_a, ds_src_b  in  32  operands
- ds_rf_we  in  1  instruction writes the GPR
- es_allowin  out  1  EX can accept
- alu_a, alu_b  out  32  registered operands to ALU
- alu_op  out  4  registered aluop
- alu_result  in  32  ALU result, combinational from alu_a/alu_b/alu_op
- alu_overflow  in  1  ALU overflow flag
- md_start  out  1  one-cycle launch pulse to mul/div unit
- md_div, md_signed  out  1  operation select, valid with md_start
- md_cancel  out  1  one-cycle abort pulse
- md_done  in  1  one-cycle completion pulse
- md_hi, md_lo  in  32  mul/div results, valid with md_done
- ms_allowin  in  1  memory stage can accept
- flush  in  1  squash the EX instruction (exception or eret)
- es_to_ms_valid  out  1  result valid toward MEM
- es_result  out  32  GPR result (ALU result; md_lo for MUL/DIV)
- es_hilo  out  64  {hi,lo} for MUL/DIV
- es_hilo_we, es_rf_we, es_ex, es_md_err  out  1  writeback enables and error flags

## Operation
- States: IDLE, ALU, MD_ISSUE, MD_WAIT, MD_HOLD.
- Acceptance: when ds_to_es_valid && es_allowin, operands, class, op, and rf_we are registered. es_allowin = !es_valid || (es_ready_go && ms_allowin).
- ALU/ALU-trap → ALU state. es_ready_go = 1. es_result = alu_result.
- Overflow handling: es_ex = (class==ALU-trap) && alu_overflow. es_rf_we = rf_we && !es_ex.
- MUL/DIV → MD_ISSUE: md_start is high for exactly that cycle, then MD_WAIT. es_ready_go = 0 until done.
- MD_WAIT: on md_done, capture {md_hi, md_lo} → MD_HOLD, es_ready_go = 1, es_hilo_we = 1, es_rf_we = 0.
- MD_WAIT timeout: a wait counter is cleared at MD_ISSUE. When it reaches MD_TIMEOUT: md_cancel pulses, es_md_err = 1, hilo = 0 → MD_HOLD.
- Leaving ALU/MD_HOLD: when ms_allowin, leave. Back-to-back: a new acceptance in the same cycle goes directly to the new op's state. Otherwise go to IDLE.
- Flush, highest priority: es_valid clears next cycle and the state goes to IDLE. If the state is MD_ISSUE/MD_WAIT, md_cancel pulses for one cycle. An md_done arriving the same cycle is discarded. No acceptance in a flush cycle.
- md_done outside MD_WAIT is ignored.

## Timing
- Reset: state IDLE. All outputs 0, except es_allowin = 1.
- ALU op accepted in cycle N: es_to_ms_valid in N+1. If ms_allowin, it is handed over at the end of N+1. Throughput is one per cycle.
- MUL/DIV accepted in N: md_start in N+1. md_done in cycle D → es_to_ms_valid from D+1. Minimum latency is 3 cycles.
- Stall: outputs hold stable while es_to_ms_valid && !ms_allowin.
- md_start never reasserts before done, cancel, or timeout.

## Structure
- Shared myCPU package holds:
  - ds_class encodings (CLS_ALU, CLS_TRAP, CLS_MUL, CLS_DIV);
  - state encodings;
  - the 4-bit ALU opcode constants also used by the ALU.
- No sub-module. The ALU and the mul/div unit are instantiated by the EX-stage top and connected to this controller.

## Test plan
- ALU add, a=5, b=7, ms_allowin=1, issued in consecutive cycles → es_to_ms_valid every cycle, es_result=12, es_rf_we=1.
- ALU-trap 0x7FFFFFFF+1 with overflow → es_ex=1, es_rf_we=0. The same op with class ALU → es_ex=0, es_rf_we=1.
- Signed MUL -3×4, done after 5 cycles → one md_start, es_allowin=0 while waiting, es_hilo=0xFFFFFFFF_FFFFFFF4, es_hilo_we=1.
- MUL result with ms_allowin held low 3 cycles → outputs stable, next instruction accepted only in the cycle ms_allowin rises.
- flush during MD_WAIT, with md_done in the same cycle → md_cancel pulse, no es_to_ms_valid, IDLE next cycle.
- DIV with md_done never asserted → md_cancel and es_md_err=1 at cycle MD_TIMEOUT; reset mid-wait → IDLE, all outputs 0.

Source files
------------

// File: rtl/mycpu_pkg.sv
// Shared myCPU definitions: decode instruction classes, EX-stage controller states
// and the 4-bit ALU opcodes understood by the ALU.
package mycpu_pkg;

    typedef enum logic [1:0] {
        CLS_ALU  = 2'b00,
        CLS_TRAP = 2'b01,
        CLS_MUL  = 2'b10,
        CLS_DIV  = 2'b11
    } ds_class_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ALU      = 3'd1,
        ST_MD_ISSUE = 3'd2,
        ST_MD_WAIT  = 3'd3,
        ST_MD_HOLD  = 3'd4
    } es_state_e;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    function automatic es_state_e class_to_state(input ds_class_e cls);
        return (cls == CLS_MUL || cls == CLS_DIV) ? ST_MD_ISSUE : ST_ALU;
    endfunction

endpackage

// File: rtl/mycpu_ex_ctrl.sv
// Execute-stage controller: drives the single-cycle ALU, sequences the shared
// mul/div unit over start/done/cancel, and hands results to MEM.
//
// state       | meaning
// ST_IDLE     | no instruction held
// ST_ALU      | ALU result presented, ready to hand over
// ST_MD_ISSUE | md_start pulse cycle
// ST_MD_WAIT  | waiting for md_done or timeout
// ST_MD_HOLD  | mul/div result (or timeout zeros) presented
module mycpu_ex_ctrl
    import mycpu_pkg::*;
#(
    parameter int MD_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_to_es_valid,
    input  logic [1:0]  ds_class,
    input  logic [3:0]  ds_aluop,
    input  logic [31:0] ds_src_a,
    input  logic [31:0] ds_src_b,
    input  logic        ds_rf_we,
    output logic        es_allowin,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic        alu_overflow,
    output logic        md_start,
    output logic        md_div,
    output logic        md_signed,
    output logic        md_cancel,
    input  logic        md_done,
    input  logic [31:0] md_hi,
    input  logic [31:0] md_lo,
    input  logic        ms_allowin,
    input  logic        flush,
    output logic        es_to_ms_valid,
    output logic [31:0] es_result,
    output logic [63:0] es_hilo,
    output logic        es_hilo_we,
    output logic        es_rf_we,
    output logic        es_ex,
    output logic        es_md_err
);

    localparam int CNT_W = $clog2(MD_TIMEOUT + 1);

    es_state_e        state_q, state_d;
    logic [31:0]      src_a_q, src_a_d;
    logic [31:0]      src_b_q, src_b_d;
    logic [3:0]       op_q, op_d;
    ds_class_e        cls_q, cls_d;
    logic             rf_we_q, rf_we_d;
    logic [63:0]      hilo_q, hilo_d;
    logic             md_err_q, md_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic es_valid;
    logic es_ready_go;
    logic accept;
    logic md_busy;
    logic md_timeout;

    assign es_valid    = (state_q != ST_IDLE);
    assign es_ready_go = (state_q == ST_ALU) || (state_q == ST_MD_HOLD);
    assign es_allowin  = !es_valid || (es_ready_go && ms_allowin);
    assign accept      = ds_to_es_valid && es_allowin && !flush;
    assign md_busy     = (state_q == ST_MD_ISSUE) || (state_q == ST_MD_WAIT);
    // cnt_q counts cycles since md_start; a same-cycle md_done wins over the timeout
    assign md_timeout  = (state_q == ST_MD_WAIT) && !md_done && (cnt_q == CNT_W'(MD_TIMEOUT));

    always_comb begin
        state_d  = state_q;
        src_a_d  = src_a_q;
        src_b_d  = src_b_q;
        op_d     = op_q;
        cls_d    = cls_q;
        rf_we_d  = rf_we_q;
        hilo_d   = hilo_q;
        md_err_d = md_err_q;
        cnt_d    = cnt_q;

        if (accept) begin
            src_a_d = ds_src_a;
            src_b_d = ds_src_b;
            op_d    = ds_aluop;
            cls_d   = ds_class_e'(ds_class);
            rf_we_d = ds_rf_we;
        end

        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) state_d = class_to_state(ds_class_e'(ds_class));
                end
                ST_ALU, ST_MD_HOLD: begin
                    if (ms_allowin) state_d = accept ? class_to_state(ds_class_e'(ds_class)) : ST_IDLE;
                end
                ST_MD_ISSUE: begin
                    state_d = ST_MD_WAIT;
                    cnt_d   = CNT_W'(1);
                end
                ST_MD_WAIT: begin
                    if (md_done) begin
                        hilo_d   = {md_hi, md_lo};
                        md_err_d = 1'b0;
                        state_d  = ST_MD_HOLD;
                    end else if (md_timeout) begin
                        hilo_d   = '0;
                        md_err_d = 1'b1;
                        state_d  = ST_MD_HOLD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            src_a_q  <= '0;
            src_b_q  <= '0;
            op_q     <= '0;
            cls_q    <= CLS_ALU;
            rf_we_q  <= 1'b0;
            hilo_q   <= '0;
            md_err_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            src_a_q  <= src_a_d;
            src_b_q  <= src_b_d;
            op_q     <= op_d;
            cls_q    <= cls_d;
            rf_we_q  <= rf_we_d;
            hilo_q   <= hilo_d;
            md_err_q <= md_err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign alu_a  = src_a_q;
    assign alu_b  = src_b_q;
    assign alu_op = op_q;

    assign md_start  = (state_q == ST_MD_ISSUE);
    assign md_div    = md_start && (cls_q == CLS_DIV);
    assign md_signed = md_start && op_q[0];
    assign md_cancel = (flush && md_busy) || (!flush && md_timeout);

    assign es_to_ms_valid = es_ready_go && !flush;
    assign es_ex          = (state_q == ST_ALU) && (cls_q == CLS_TRAP) && alu_overflow;
    assign es_rf_we       = (state_q == ST_ALU) && rf_we_q && !es_ex;
    assign es_result      = (state_q == ST_ALU)     ? alu_result   :
                            (state_q == ST_MD_HOLD) ? hilo_q[31:0] : 32'd0;
    assign es_hilo        = hilo_q;
    assign es_hilo_we     = (state_q == ST_MD_HOLD);
    assign es_md_err      = (!flush && md_timeout) || ((state_q == ST_MD_HOLD) && md_err_q);

endmodule

// File: tb/tb_mycpu_ex_ctrl.sv
// Directed bench for mycpu_ex_ctrl: bench models the ALU and plays the mul/div unit;
// expected handovers are queued at issue and compared when MEM accepts them.
module tb_mycpu_ex_ctrl;
    import mycpu_pkg::*;

    localparam int MD_TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        ds_to_es_valid;
    logic [1:0]  ds_class;
    logic [3:0]  ds_aluop;
    logic [31:0] ds_src_a, ds_src_b;
    logic        ds_rf_we;
    logic        es_allowin;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_overflow;
    logic        md_start, md_div, md_signed, md_cancel;
    logic        md_done;
    logic [31:0] md_hi, md_lo;
    logic        ms_allowin;
    logic        flush;
    logic        es_to_ms_valid;
    logic [31:0] es_result;
    logic [63:0] es_hilo;
    logic        es_hilo_we, es_rf_we, es_ex, es_md_err;

    typedef struct packed {
        logic [31:0] result;
        logic [63:0] hilo;
        logic        rf_we;
        logic        ex;
        logic        hilo_we;
        logic        md_err;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cnt;

    always #5 clk = ~clk;

    mycpu_ex_ctrl #(.MD_TIMEOUT(MD_TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .ds_to_es_valid(ds_to_es_valid), .ds_class(ds_class), .ds_aluop(ds_aluop),
        .ds_src_a(ds_src_a), .ds_src_b(ds_src_b), .ds_rf_we(ds_rf_we),
        .es_allowin(es_allowin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_overflow(alu_overflow),
        .md_start(md_start), .md_div(md_div), .md_signed(md_signed), .md_cancel(md_cancel),
        .md_done(md_done), .md_hi(md_hi), .md_lo(md_lo),
        .ms_allowin(ms_allowin), .flush(flush),
        .es_to_ms_valid(es_to_ms_valid), .es_result(es_result), .es_hilo(es_hilo),
        .es_hilo_we(es_hilo_we), .es_rf_we(es_rf_we), .es_ex(es_ex), .es_md_err(es_md_err)
    );

    // Reference ALU for the opcodes the bench uses
    always_comb begin
        alu_result   = 32'd0;
        alu_overflow = 1'b0;
        case (alu_op)
            ALU_ADD: begin
                alu_result   = alu_a + alu_b;
                alu_overflow = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            ALU_SUB: begin
                alu_result   = alu_a - alu_b;
                alu_overflow = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            ALU_AND: alu_result = alu_a & alu_b;
            ALU_OR:  alu_result = alu_a | alu_b;
            default: alu_result = 32'd0;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] r, input logic [63:0] h,
                        input logic rf, input logic ex, input logic hwe, input logic err);
        exp_t e;
        e.result  = r;
        e.hilo    = h;
        e.rf_we   = rf;
        e.ex      = ex;
        e.hilo_we = hwe;
        e.md_err  = err;
        sb.push_back(e);
    endtask

    task automatic drive(input logic v, input logic [1:0] cls, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic rfwe);
        ds_to_es_valid = v;
        ds_class       = cls;
        ds_aluop       = op;
        ds_src_a       = a;
        ds_src_b       = b;
        ds_rf_we       = rfwe;
    endtask

    // Scoreboard pop on handover, then advance to 1 time unit after the next edge
    task automatic cyc();
        exp_t e;
        if (es_to_ms_valid && ms_allowin) begin
            check("handover_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("result", 64'(es_result), 64'(e.result));
                check("flags_rfwe_ex_hilowe_err", 64'({es_rf_we, es_ex, es_hilo_we, es_md_err}),
                      64'({e.rf_we, e.ex, e.hilo_we, e.md_err}));
                if (e.hilo_we) check("hilo", es_hilo, e.hilo);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_allowin"}, 64'(es_allowin), 64'd1);
        check({tag, "_ctrl"}, 64'({es_to_ms_valid, md_start, md_div, md_signed, md_cancel,
                                   es_rf_we, es_ex, es_hilo_we, es_md_err}), 64'd0);
        check({tag, "_alu_ab"}, {alu_a, alu_b}, 64'd0);
        check({tag, "_alu_op_result"}, 64'({alu_op, es_result}), 64'd0);
        check({tag, "_hilo"}, es_hilo, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        drive(1'b0, 2'b00, 4'd0, 32'd0, 32'd0, 1'b0);
        md_done = 1'b0; md_hi = 32'd0; md_lo = 32'd0;
        ms_allowin = 1'b1; flush = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check_idle_outputs("reset");
        reset = 1'b0;
        cyc();

        // Back-to-back ALU adds, one handover per cycle
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, CLS_ALU, ALU_ADD, 32'd5, 32'd7, 1'b1);
            push(32'd12, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0);
            #1;
            check("alu_allowin", 64'(es_allowin), 64'd1);
            if (i > 0) check("alu_b2b_valid", 64'(es_to_ms_valid), 64'd1);
            cyc();
        end
        drive(1'b0, CLS_ALU, ALU_ADD, 32'd0, 32'd0, 1'b0);
        #1;
        check("alu_last_valid", 64'(es_to_ms_valid), 64'd1);
        cyc();
        #1;
        check("alu_drained", 64'(es_to_ms_valid), 64'd0);
        cyc();

        // Overflow: trap class raises es_ex and kills writeback, plain ALU does not
        drive(1'b1, CLS_TRAP, ALU_ADD, 32'h7FFF_FFFF, 32'd1, 1'b1);
        push(32'h8000_0000, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        cyc();
        drive(1'b1, CLS_ALU, ALU_ADD, 32'h7FFF_FFFF, 32'd1, 1'b1);
        push(32'h8000_0000, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("trap_ex", 64'(es_ex), 64'd1);
        check("trap_rf_we", 64'(es_rf_we), 64'd0);
        cyc();
        drive(1'b0, CLS_ALU, ALU_ADD, 32'd0, 32'd0, 1'b0);
        #1;
        check("alu_ovf_no_ex", 64'(es_ex), 64'd0);
        cyc();

        // Signed MUL -3 x 4, md_done five cycles after md_start
        drive(1'b1, CLS_MUL, 4'b0001, 32'hFFFF_FFFD, 32'd4, 1'b1);
        push(32'hFFFF_FFF4, 64'hFFFF_FFFF_FFFF_FFF4, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        check("mul_accept", 64'(es_allowin), 64'd1);
        cyc();
        drive(1'b0, CLS_ALU, 4'd0, 32'd0, 32'd0, 1'b0);
        #1;
        check("mul_issue", 64'({md_start, md_signed, md_div, es_allowin}), 64'b1100);
        check("mul_issue_operands", {alu_a, alu_b}, {32'hFFFF_FFFD, 32'd4});
        cyc();
        cnt = 0;
        for (int k = 1; k < 5; k++) begin
            #1;
            if (md_start || es_allowin || es_to_ms_valid) cnt++;
            cyc();
        end
        check("mul_wait_quiet", 64'(cnt), 64'd0);
        md_done = 1'b1; md_hi = 32'hFFFF_FFFF; md_lo = 32'hFFFF_FFF4;
        #1;
        check("mul_done_cycle_valid", 64'(es_to_ms_valid), 64'd0);
        cyc();
        md_done = 1'b0; md_hi = 32'd0; md_lo = 32'd0;
        #1;
        check("mul_hold_valid", 64'({es_to_ms_valid, es_hilo_we}), 64'b11);
        cyc();

        // Unsigned MUL 6 x 7 at minimum latency, then MEM stalls for three cycles
        drive(1'b1, CLS_MUL, 4'b0000, 32'd6, 32'd7, 1'b1);
        push(32'd42, 64'd42, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        cyc();
        drive(1'b0, CLS_ALU, 4'd0, 32'd0, 32'd0, 1'b0);
        #1;
        check("mulu_issue", 64'({md_start, md_signed}), 64'b10);
        cyc();
        md_done = 1'b1; md_lo = 32'd42; ms_allowin = 1'b0;
        #1;
        cyc();
        md_done = 1'b0; md_lo = 32'd0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, CLS_ALU, ALU_SUB, 32'd20, 32'd8, 1'b1);
            #1;
            check("stall_valid_allowin", 64'({es_to_ms_valid, es_allowin}), 64'b10);
            check("stall_hilo", es_hilo, 64'd42);
            check("stall_result", 64'(es_result), 64'd42);
            cyc();
        end
        ms_allowin = 1'b1;
        #1;
        check("stall_release_allowin", 64'(es_allowin), 64'd1);
        push(32'd12, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc();
        drive(1'b0, CLS_ALU, 4'd0, 32'd0, 32'd0, 1'b0);
        #1;
        cyc();

        // Flush during MD_WAIT with a coincident md_done
        drive(1'b1, CLS_DIV, 4'b0001, 32'd100, 32'd7, 1'b1);
        #1;
        cyc();
        drive(1'b0, CLS_ALU, 4'd0, 32'd0, 32'd0, 1'b0);
        #1;
        check("div_issue", 64'({md_start, md_div, md_signed}), 64'b111);
        cyc();
        #1;
        cyc();
        flush = 1'b1; md_done = 1'b1; md_hi = 32'd2; md_lo = 32'd14;
        #1;
        check("flush_cancel", 64'({md_cancel, es_to_ms_valid}), 64'b10);
        cyc();
        flush = 1'b0; md_done = 1'b0; md_hi = 32'd0; md_lo = 32'd0;
        #1;
        check("flush_idle", 64'({es_allowin, es_to_ms_valid, md_cancel, es_hilo_we, md_start}),
              64'b10000);
        cyc();

        // DIV whose md_done never arrives: cancel and error MD_TIMEOUT cycles after md_start
        drive(1'b1, CLS_DIV, 4'b0000, 32'd9, 32'd0, 1'b1);
        push(32'd0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        cyc();
        drive(1'b0, CLS_ALU, 4'd0, 32'd0, 32'd0, 1'b0);
        #1;
        check("tmo_issue", 64'({md_start, md_div}), 64'b11);
        cyc();
        cnt = 0;
        for (int k = 1; k < MD_TIMEOUT; k++) begin
            #1;
            if (md_cancel || es_md_err || md_start || es_to_ms_valid) cnt++;
            cyc();
        end
        check("tmo_early", 64'(cnt), 64'd0);
        #1;
        check("tmo_cancel_err", 64'({md_cancel, es_md_err, es_to_ms_valid}), 64'b110);
        cyc();
        #1;
        check("tmo_hold", 64'({es_to_ms_valid, md_cancel, es_md_err}), 64'b101);
        cyc();

        // Reset in the middle of a mul/div wait
        drive(1'b1, CLS_MUL, 4'b0001, 32'd3, 32'd3, 1'b1);
        #1;
        cyc();
        drive(1'b0, CLS_ALU, 4'd0, 32'd0, 32'd0, 1'b0);
        #1;
        cyc();
        repeat (10) begin
            #1;
            cyc();
        end
        #1;
        check("pre_reset_busy", 64'(es_allowin), 64'd0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        check_idle_outputs("midwait_reset");
        cyc();

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
